// File: rtl/mem_data_access.sv
// MEM-stage data-memory access unit: single-outstanding req/ack bus master
// with byte lanes, load extension, alignment and timeout exceptions.
package mem_data_access_pkg;
    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } Oper_t;
endpackage

module mem_data_access
    import mem_data_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        oper_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              flush_i,
    output logic              stall_req_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              excp_adel_o,
    output logic              excp_ades_o,
    output logic              excp_bus_err_o,
    output logic [ADDR_W-1:0] bad_vaddr_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_be_o,
    output logic [31:0]       bus_wdata_o,
    input  logic [31:0]       bus_rdata_i,
    input  logic              bus_ack_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [3:0]          bus_be_q, bus_be_d;
    logic [31:0]         bus_wdata_q, bus_wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          op_q, op_d;
    logic                load_q, load_d;
    logic                err_q, err_d;
    logic                discard_q, discard_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         rdata_q, rdata_d;

    logic is_mem, is_load, is_byte, is_half, is_word;
    logic misal, idle, go, bad_op;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] lane_sh;
    logic [15:0] half_sel;
    logic [31:0] ext;

    always_comb begin
        is_mem  = 1'b0;
        is_load = 1'b0;
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        case (oper_i)
            OP_LB, OP_LBU: begin is_mem = 1'b1; is_load = 1'b1; is_byte = 1'b1; end
            OP_LH, OP_LHU: begin is_mem = 1'b1; is_load = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_mem = 1'b1; is_load = 1'b1; is_word = 1'b1; end
            OP_SB:         begin is_mem = 1'b1; is_byte = 1'b1; end
            OP_SH:         begin is_mem = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_mem = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign misal  = (is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00));
    assign idle   = (state_q == S_IDLE);
    assign go     = idle & is_mem & ~misal & ~flush_i;
    assign bad_op = idle & is_mem & misal & ~flush_i;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
        if (is_byte) begin
            be_new    = 4'b0001 << addr_i[1:0];
            wdata_new = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{wdata_i[15:0]}};
        end
    end

    // Lane extraction uses the address latched at issue, not the live input.
    assign lane_sh  = bus_rdata_i >> {addr_q[1:0], 3'b000};
    assign half_sel = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    always_comb begin
        case (op_q)
            OP_LB:   ext = {{24{lane_sh[7]}}, lane_sh[7:0]};
            OP_LBU:  ext = {24'h0, lane_sh[7:0]};
            OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ext = {16'h0, half_sel};
            default: ext = bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        addr_d      = addr_q;
        op_d        = op_q;
        load_d      = load_q;
        err_d       = err_q;
        discard_d   = discard_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = ~is_load;
                    bus_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                    bus_be_d    = be_new;
                    bus_wdata_d = wdata_new;
                    addr_d      = addr_i;
                    op_d        = oper_i;
                    load_d      = is_load;
                    err_d       = 1'b0;
                    discard_d   = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_i) discard_d = 1'b1;
                if (bus_ack_i) begin
                    if (load_q) rdata_d = ext;
                    bus_req_d = 1'b0;
                    state_d   = S_DONE;
                end else if (TIMEOUT_CYCLES != 0 &&
                             cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0;
            bus_wdata_q <= 32'b0;
            addr_q      <= '0;
            op_q        <= 4'b0;
            load_q      <= 1'b0;
            err_q       <= 1'b0;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= 32'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            load_q      <= load_d;
            err_q       <= err_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    logic done_ok;
    assign done_ok = (state_q == S_DONE) & ~discard_q;

    assign stall_req_o    = go | (state_q == S_REQ);
    assign rdata_o        = rdata_q;
    assign rdata_valid_o  = done_ok & load_q & ~err_q;
    assign excp_adel_o    = bad_op & is_load;
    assign excp_ades_o    = bad_op & ~is_load;
    assign excp_bus_err_o = done_ok & err_q;
    assign bad_vaddr_o    = bad_op ? addr_i :
                            (excp_bus_err_o ? addr_q : '0);
    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_be_o       = bus_be_q;
    assign bus_wdata_o    = bus_wdata_q;

endmodule

// File: tb/tb_mem_data_access.sv
// Directed bench for mem_data_access: loads, stores, alignment faults,
// flush during a transfer and bus timeout on a short-timeout instance.
module tb_mem_data_access;
    import mem_data_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  oper, oper2;
    logic [31:0] addr, wdata, bus_rdata;
    logic        flush, bus_ack;
    logic        ack2 = 1'b0;

    logic        stall, rvalid, adel, ades, berr, req, we;
    logic [31:0] rdata, bad, baddr, bwdata;
    logic [3:0]  be;

    logic        stall2, rvalid2, adel2, ades2, berr2, req2, we2;
    logic [31:0] rdata2, bad2, baddr2, bwdata2;
    logic [3:0]  be2;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_data_access u_dut (
        .clk(clk), .rst(rst), .oper_i(oper), .addr_i(addr),
        .wdata_i(wdata), .flush_i(flush), .stall_req_o(stall),
        .rdata_o(rdata), .rdata_valid_o(rvalid), .excp_adel_o(adel),
        .excp_ades_o(ades), .excp_bus_err_o(berr), .bad_vaddr_o(bad),
        .bus_req_o(req), .bus_we_o(we), .bus_addr_o(baddr),
        .bus_be_o(be), .bus_wdata_o(bwdata), .bus_rdata_i(bus_rdata),
        .bus_ack_i(bus_ack)
    );

    mem_data_access #(.TIMEOUT_CYCLES(4)) u_to (
        .clk(clk), .rst(rst), .oper_i(oper2), .addr_i(addr),
        .wdata_i(wdata), .flush_i(flush), .stall_req_o(stall2),
        .rdata_o(rdata2), .rdata_valid_o(rvalid2), .excp_adel_o(adel2),
        .excp_ades_o(ades2), .excp_bus_err_o(berr2), .bad_vaddr_o(bad2),
        .bus_req_o(req2), .bus_we_o(we2), .bus_addr_o(baddr2),
        .bus_be_o(be2), .bus_wdata_o(bwdata2), .bus_rdata_i(bus_rdata),
        .bus_ack_i(ack2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic load_txn(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] rd, input logic [3:0] xbe,
                            input logic [31:0] xr);
        @(negedge clk); oper = op; addr = a; #1;
        chk("ld_go_stall", {31'b0, stall}, 1);
        chk("ld_go_noreq", {31'b0, req}, 0);
        @(negedge clk); bus_ack = 1'b1; bus_rdata = rd; #1;
        chk("ld_req", {31'b0, req}, 1);
        chk("ld_we", {31'b0, we}, 0);
        chk("ld_addr", baddr, a & 32'hFFFF_FFFC);
        chk("ld_be", {28'b0, be}, {28'b0, xbe});
        chk("ld_req_stall", {31'b0, stall}, 1);
        @(negedge clk); bus_ack = 1'b0; bus_rdata = 32'h0; #1;
        chk("ld_done_stall", {31'b0, stall}, 0);
        chk("ld_done_valid", {31'b0, rvalid}, 1);
        chk("ld_done_rdata", rdata, xr);
        chk("ld_done_noreq", {31'b0, req}, 0);
        @(negedge clk); oper = OP_NONE; #1;
        chk("ld_idle_valid", {31'b0, rvalid}, 0);
        chk("ld_idle_hold", rdata, xr);
        chk("ld_idle_noreq", {31'b0, req}, 0);
    endtask

    task automatic store_txn(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] xbe,
                             input logic [31:0] xwd);
        @(negedge clk); oper = op; addr = a; wdata = wd; #1;
        chk("st_go_stall", {31'b0, stall}, 1);
        @(negedge clk); bus_ack = 1'b1; #1;
        chk("st_req", {31'b0, req}, 1);
        chk("st_we", {31'b0, we}, 1);
        chk("st_addr", baddr, a & 32'hFFFF_FFFC);
        chk("st_be", {28'b0, be}, {28'b0, xbe});
        chk("st_wdata", bwdata, xwd);
        @(negedge clk); bus_ack = 1'b0; #1;
        chk("st_done_stall", {31'b0, stall}, 0);
        chk("st_done_valid", {31'b0, rvalid}, 0);
        chk("st_done_noreq", {31'b0, req}, 0);
        @(negedge clk); oper = OP_NONE; wdata = 32'h0; #1;
        chk("st_idle_noreq", {31'b0, req}, 0);
    endtask

    initial begin
        rst = 1'b1; oper = OP_NONE; oper2 = OP_NONE;
        addr = 32'h0; wdata = 32'h0; flush = 1'b0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_req", {31'b0, req}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_valid", {31'b0, rvalid}, 0);
        chk("rst_excp", {29'b0, adel, ades, berr}, 0);
        chk("rst_bad", bad, 0);
        chk("rst_be", {28'b0, be}, 0);
        chk("rst_baddr", baddr, 0);

        load_txn(OP_LW,  32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        load_txn(OP_LB,  32'h8000_0013, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
        load_txn(OP_LBU, 32'h8000_0013, 32'h80FF_0000, 4'b1000, 32'h0000_0080);
        load_txn(OP_LHU, 32'h8000_0006, 32'hBEEF_1234, 4'b1100, 32'h0000_BEEF);
        load_txn(OP_LH,  32'h8000_0000, 32'h0000_8001, 4'b0011, 32'hFFFF_8001);
        load_txn(OP_LB,  32'h8000_0001, 32'h0000_7F00, 4'b0010, 32'h0000_007F);

        store_txn(OP_SH, 32'h8000_0022, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        store_txn(OP_SB, 32'h8000_0001, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A);
        store_txn(OP_SW, 32'h8000_0030, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // misaligned load then store
        @(negedge clk); oper = OP_LW; addr = 32'h8000_1002; #1;
        chk("adel", {31'b0, adel}, 1);
        chk("adel_ades", {31'b0, ades}, 0);
        chk("adel_bad", bad, 32'h8000_1002);
        chk("adel_stall", {31'b0, stall}, 0);
        @(negedge clk); oper = OP_SW; #1;
        chk("adel_noreq", {31'b0, req}, 0);
        chk("ades", {31'b0, ades}, 1);
        chk("ades_adel", {31'b0, adel}, 0);
        chk("ades_bad", bad, 32'h8000_1002);
        @(negedge clk); oper = OP_LH; addr = 32'h8000_1001; flush = 1'b1; #1;
        chk("ades_noreq", {31'b0, req}, 0);
        chk("adel_flushed", {31'b0, adel}, 0);
        chk("bad_flushed", bad, 0);
        @(negedge clk); oper = OP_LW; addr = 32'h8000_0040; #1;
        chk("flush_idle_stall", {31'b0, stall}, 0);
        @(negedge clk); oper = OP_NONE; flush = 1'b0; #1;
        chk("flush_idle_noreq", {31'b0, req}, 0);

        // flush during an outstanding load
        @(negedge clk); oper = OP_LH; addr = 32'h8000_0004; #1;
        chk("fl_go_stall", {31'b0, stall}, 1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            flush = (i == 2);
            bus_ack = (i == 5);
            bus_rdata = 32'h1234_5678;
            #1;
            chk("fl_req", {31'b0, req}, 1);
            chk("fl_stall", {31'b0, stall}, 1);
        end
        @(negedge clk); flush = 1'b0; bus_ack = 1'b0; #1;
        chk("fl_done_valid", {31'b0, rvalid}, 0);
        chk("fl_done_stall", {31'b0, stall}, 0);
        chk("fl_done_berr", {31'b0, berr}, 0);
        chk("fl_done_noreq", {31'b0, req}, 0);
        @(negedge clk); oper = OP_NONE; #1;
        chk("fl_idle_noreq", {31'b0, req}, 0);

        // timeout on the short-timeout instance
        @(negedge clk); oper2 = OP_LW; addr = 32'h8000_0040; #1;
        chk("to_go_stall", {31'b0, stall2}, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #1;
            chk("to_req", {31'b0, req2}, 1);
            chk("to_stall", {31'b0, stall2}, 1);
        end
        @(negedge clk); #1;
        chk("to_done_noreq", {31'b0, req2}, 0);
        chk("to_done_berr", {31'b0, berr2}, 1);
        chk("to_done_bad", bad2, 32'h8000_0040);
        chk("to_done_valid", {31'b0, rvalid2}, 0);
        chk("to_done_stall", {31'b0, stall2}, 0);
        @(negedge clk); oper2 = OP_NONE; #1;
        chk("to_idle_berr", {31'b0, berr2}, 0);
        chk("to_idle_noreq", {31'b0, req2}, 0);
        chk("to_idle_bad", bad2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_data_access.md
Name: mem_data_access

Overview:
- MEM-stage data-memory access unit. Consumes the memory-operation fields latched by the EX/MEM pipeline register (operation, address, store data).
- Drives a single-outstanding req/ack data bus with byte enables, and holds the pipeline via stall_req until the transfer completes.
- Returns the lane-extracted, sign- or zero-extended load result to the MEM/WB path.
- Flags misaligned accesses (AdEL/AdES) and bus timeouts to the exception logic.

Parameters:
TIMEOUT_CYCLES, 255, max cycles bus_req may wait for bus_ack before aborting; 0 disables timeout
ADDR_W, 32, address width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
oper  in  Oper_t  MEM-stage operation; OP_LB/LBU/LH/LHU/LW/SB/SH/SW access memory, all other values are no access
addr  in  ADDR_W  virtual byte address of access
wdata  in  32  store data (low bits significant for SB/SH)
flush  in  1  pipeline flush for current MEM instruction
stall_req  out  1  hold pipeline at and before MEM
rdata  out  32  extended load result
rdata_valid  out  1  rdata valid for current load (DONE cycle only)
excp_adel  out  1  load address misaligned
excp_ades  out  1  store address misaligned
excp_bus_err  out  1  bus timeout
bad_vaddr  out  ADDR_W  faulting address
bus_req  out  1  bus request, held until ack
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
bus_be  out  4  byte enables, lane i = bits 8i+7:8i (little-endian)
bus_wdata  out  32  lane-replicated store data
bus_rdata  in  32  read data, valid with bus_ack
bus_ack  in  1  transfer complete (one cycle)

Behaviour:
- FSM states IDLE, REQ, DONE.
- Reset values: state IDLE; all outputs 0, including bus_*, rdata, rdata_valid, exception flags, bad_vaddr, timeout counter.
- A mem op is "go" when in IDLE with a memory oper, aligned, and flush=0.
- Alignment rules:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - Byte ops are always aligned.
- Misaligned op in IDLE (combinational, same cycle):
  - excp_adel (loads) or excp_ades (stores) = 1, bad_vaddr = addr.
  - stall_req = 0; no bus activity; state stays IDLE.
  - Suppressed if flush=1.
- IDLE with go:
  - stall_req = 1 combinationally.
  - Next edge: register bus_req=1, bus_we, bus_addr, bus_be, bus_wdata; clear timeout counter; enter REQ.
- REQ:
  - stall_req = 1; bus outputs held stable; counter increments each cycle bus_ack=0.
  - On bus_ack=1: capture and extend bus_rdata into rdata (loads), drop bus_req, enter DONE.
  - If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without ack: drop bus_req, set err flag, enter DONE.
- DONE (exactly one cycle):
  - stall_req = 0.
  - rdata_valid = 1 for a load that completed without timeout or flush.
  - excp_bus_err = 1 with bad_vaddr = latched addr on timeout.
  - Unconditionally return to IDLE. The oper still present in DONE is never reissued.
- Latency: go cycle -> bus_req next cycle -> DONE one cycle after ack. Minimum 3 cycles (ack in first REQ cycle).
- Byte enables:
  - SB/LB/LBU: be = 4'b0001 << addr[1:0]; wdata byte replicated to all four lanes.
  - SH/LH/LHU: be = addr[1] ? 4'b1100 : 4'b0011; halfword replicated to both halves.
  - SW/LW: be = 4'b1111.
- Load extension: lane selected by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through. rdata holds its value outside DONE.
- Flush in REQ:
  - Transaction is not aborted; bus_req held until ack or timeout; stall_req stays 1.
  - Sticky discard flag set; DONE then has rdata_valid=0, excp_bus_err=0.
  - Stores already issued complete on the bus.
- Flush in IDLE: no transaction, no exception.
- Flush in DONE: ignored.
- Reset mid-transaction: immediate return to IDLE, bus_req=0 next edge. The bus slave must tolerate an abandoned request.
- Only one outstanding transaction; bus_ack outside REQ is ignored.

Test Plan:
- LW addr 0x8000_0010, bus_ack in first REQ cycle with bus_rdata 0xDEAD_BEEF -> bus_addr 0x8000_0010, be 1111, stall_req high 2 cycles, DONE: rdata 0xDEAD_BEEF, rdata_valid 1.
- LB addr 0x8000_0013, bus_rdata 0x80FF_0000 -> be 1000, rdata 0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- SH addr 0x8000_0022, wdata 0x1234_ABCD -> bus_we 1, bus_addr 0x8000_0020, be 1100, bus_wdata 0xABCD_ABCD.
- LW addr 0x8000_1002 -> excp_adel 1, bad_vaddr 0x8000_1002, stall_req 0, bus_req never asserted. SW same address -> excp_ades 1.
- LH addr 0x8000_0004, ack after 5 REQ cycles, flush pulsed in REQ cycle 2 -> bus_req held 5 cycles, stall_req high throughout, DONE rdata_valid 0.
- TIMEOUT_CYCLES=4, LW with no ack -> bus_req high 4 cycles then 0, DONE excp_bus_err 1, bad_vaddr = addr, next cycle IDLE.
